// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_pkg: shared types and constants for the memory access controller.
//   state_t     : controller FSM states (IDLE, ACCESS, DONE)
//   MEM_ADDR_W  : default address width (MAR width)
//   MEM_DATA_W  : default data word width
//   WAIT_CNT_W  : width of the wait-state down-counter (0..15 wait states)
package mem_access_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake between the control unit
// (MAR/MDR side) and the memory access controller.
//   mar_addr    : address from the MAR register
//   mem_rd_req  : read request
//   mem_wr_req  : write request
//   mem_wr_data : write data from MDR/data bus
//   mem_rd_data : captured read data towards the MDR
//   mem_ack     : one-cycle completion pulse
//   mem_busy    : access in progress
//   mem_fault   : address-limit fault, qualified by mem_ack
// Modports: master = control unit, slave = memory access controller.
interface mem_access_ctrl_if
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
  parameter int unsigned DATA_WIDTH = MEM_DATA_W
);

  logic [ADDR_WIDTH-1:0] mar_addr;
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_ack;
  logic                  mem_busy;
  logic                  mem_fault;

  modport master (
    output mar_addr,
    output mem_rd_req,
    output mem_wr_req,
    output mem_wr_data,
    input  mem_rd_data,
    input  mem_ack,
    input  mem_busy,
    input  mem_fault
  );

  modport slave (
    input  mar_addr,
    input  mem_rd_req,
    input  mem_wr_req,
    input  mem_wr_data,
    output mem_rd_data,
    output mem_ack,
    output mem_busy,
    output mem_fault
  );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// mem_wait_counter: loadable down-counter that sets the ACCESS dwell time.
//   clk      : system clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; saturates at zero
//   zero     : count is zero
module mem_wait_counter
  import mem_access_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-side responder for the address path. Accepts a read
// or write request in IDLE, drives the RAM for WAIT_STATES+1 cycles, captures
// read data for the MDR and returns a one-cycle mem_ack.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : mem_access_ctrl_if.slave (MAR address, requests, MDR data,
//                ack/busy/fault)
//   ram_addr   : RAM address (latched, stable during ACCESS)
//   ram_wdata  : RAM write data (latched, stable during ACCESS)
//   ram_rdata  : RAM read data, sampled at the last ACCESS edge
//   ram_en     : RAM enable, high only in ACCESS
//   ram_we     : RAM write enable, high only in ACCESS for writes
// Optional feature: define MEM_ADDR_LIMIT_EN to fault any access whose address
// is >= ADDR_LIMIT; such an access skips the RAM and acks one cycle after
// acceptance with mem_fault=1 (reads return all ones).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = MEM_ADDR_W,
  parameter int unsigned           DATA_WIDTH  = MEM_DATA_W,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = ADDR_WIDTH'(16'hF000)
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_en,
  output logic                  ram_we
);

  // The wait counter is 4 bits wide, so more than 15 wait states cannot be met.
  if (WAIT_STATES > ((32'd1 << WAIT_CNT_W) - 32'd1)) begin : g_bad_wait_states
    $error("mem_access_ctrl: WAIT_STATES=%0d does not fit the wait counter", WAIT_STATES);
  end

  // A zero limit would make every access fault when the limit is enabled.
  if (ADDR_LIMIT == '0) begin : g_bad_addr_limit
    $error("mem_access_ctrl: ADDR_LIMIT must be non-zero");
  end

  state_t                state_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  ack_r;
  logic                  busy_r;
  logic                  fault_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic                  ram_en_r;
  logic                  ram_we_r;

  logic                  req_s;
  logic                  load_s;
  logic                  dec_s;
  logic                  cnt_zero_s;
  logic                  limit_hit_s;

  assign req_s  = bus.mem_rd_req || bus.mem_wr_req;
  assign load_s = (state_r == IDLE) && req_s;
  assign dec_s  = (state_r == ACCESS) && !cnt_zero_s;

`ifdef MEM_ADDR_LIMIT_EN
  assign limit_hit_s = (bus.mar_addr >= ADDR_LIMIT);
`else
  // No comparator: every address reaches the RAM and fault_r stays at zero.
  assign limit_hit_s = 1'b0;
`endif

  mem_wait_counter #(
    .W (WAIT_CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (WAIT_CNT_W'(WAIT_STATES)),
    .dec      (dec_s),
    .zero     (cnt_zero_s)
  );

  // Controller FSM with all externally visible outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_data_r   <= '0;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      fault_r     <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          fault_r <= 1'b0;
          if (req_s) begin
            ram_addr_r  <= bus.mar_addr;
            ram_wdata_r <= bus.mem_wr_data;
            if (limit_hit_s) begin
              // Illegal address: skip the RAM entirely and ack next cycle.
              state_r <= DONE;
              ack_r   <= 1'b1;
              fault_r <= 1'b1;
              if (!bus.mem_wr_req) begin
                rd_data_r <= '1;
              end else begin
                rd_data_r <= rd_data_r;
              end
            end else begin
              // Write wins over a simultaneous read.
              state_r  <= ACCESS;
              busy_r   <= 1'b1;
              ram_en_r <= 1'b1;
              ram_we_r <= bus.mem_wr_req;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ACCESS: begin
          if (cnt_zero_s) begin
            // ram_we_r still holds the operation type of this access.
            if (!ram_we_r) begin
              rd_data_r <= ram_rdata;
            end else begin
              rd_data_r <= rd_data_r;
            end
            state_r  <= DONE;
            ack_r    <= 1'b1;
            busy_r   <= 1'b0;
            ram_en_r <= 1'b0;
            ram_we_r <= 1'b0;
          end else begin
            state_r <= ACCESS;
          end
        end

        DONE: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          fault_r <= 1'b0;
        end

        default: begin
          state_r  <= IDLE;
          ack_r    <= 1'b0;
          busy_r   <= 1'b0;
          fault_r  <= 1'b0;
          ram_en_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd_data = rd_data_r;
  assign bus.mem_ack     = ack_r;
  assign bus.mem_busy    = busy_r;
  assign bus.mem_fault   = fault_r;
  assign ram_addr        = ram_addr_r;
  assign ram_wdata       = ram_wdata_r;
  assign ram_en          = ram_en_r;
  assign ram_we          = ram_we_r;

endmodule
